bin_to_bcd_seq: RTL and testbench

Sequential double-dabble converter from an unsigned WIDTH-bit binary word to NDIG packed BCD digits. It sits directly upstream of the 4-bit binary-to-Excess-3 converter. Every digit it emits is a 4-bit value in 0–9, which that converter maps to Excess-3 without ever hitting its don't-care range. It performs one shift-and-adjust step per clock and uses a valid/ready handshake on both sides.

---
 rtl/bcd_pkg.sv | 33 +++
 rtl/bcd_adjust_digit.sv | 17 +
 rtl/bin_to_bcd_seq.sv | 183 ++++++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Holds the FSM state encoding, the digit constants, and the helper that the
// top uses to reject a digit count that is too small for the input width.
package bcd_pkg;

  localparam int DIGIT_W   = 4;
  localparam int MAX_DIGIT = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Smallest digit count whose decimal range covers 2^width - 1.
  function automatic int min_ndig(input int width);
    longint max_val;
    longint pow10;
    int     n;
    max_val = (longint'(1) << width) - 1;
    pow10   = 10;
    n       = 1;
    for (int i = 0; i < 8; i++) begin
      if (pow10 <= max_val) begin
        n     = n + 1;
        pow10 = pow10 * 10;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_adjust_digit.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or
// more, so that the following left shift carries correctly into the next
// decade. The 4-bit sum never carries out for inputs 0..9.
module bcd_adjust_digit
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_in,
  output logic [DIGIT_W-1:0] digit_out
);

  // Conditional +3 correction.
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= DIGIT_W'(5)) digit_out = digit_in + DIGIT_W'(3);
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: unsigned WIDTH-bit binary in, NDIG
// packed BCD digits out, one shift-and-adjust step per clock. Valid/ready on
// both the input and the result side.
//
// Optional feature macro: BCD_DIGIT_STREAM_EN
//   defined   - after conversion the digits are streamed LSD first on
//               DIGIT_OUT/DIGIT_VALID/DIGIT_LAST with DIGIT_READY back-pressure
//               before the packed result is offered.
//   undefined - SHIFT goes straight to DONE; DIGIT_* outputs are tied to 0 and
//               DIGIT_READY is ignored. Port list is identical in both builds.
//
// state  | meaning
// IDLE   | waiting for IN_VALID, IN_READY high
// SHIFT  | one adjust+shift step per clock, WIDTH steps total
// STREAM | presenting digit[idx] to the downstream Excess-3 stage
// DONE   | OUT_VALID high, holding BCD_OUT until OUT_READY
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NDIG  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      B_IN,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [4*NDIG-1:0]     BCD_OUT,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [3:0]            DIGIT_OUT,
  output logic                  DIGIT_VALID,
  output logic                  DIGIT_LAST,
  input  logic                  DIGIT_READY
);

  localparam int BCD_W = DIGIT_W * NDIG;
  localparam int SR_W  = BCD_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
    $error("bin_to_bcd_seq: WIDTH must be in 4..16");
  end
  if (NDIG < min_ndig(WIDTH)) begin : g_bad_ndig
    $error("bin_to_bcd_seq: NDIG too small to hold 2^WIDTH-1");
  end

  state_t            state;
  logic [SR_W-1:0]   sreg;
  logic [SR_W-1:0]   sreg_shl;
  logic [BCD_W-1:0]  adj_bcd;
  logic [CNT_W-1:0]  cnt;

  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_adjust_digit u_adj (
      .digit_in  (sreg[WIDTH + g*DIGIT_W +: DIGIT_W]),
      .digit_out (adj_bcd[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Adjusted BCD field followed by the remaining binary bits, shifted left by one.
  assign sreg_shl = {adj_bcd[BCD_W-2:0], sreg[WIDTH-1:0], 1'b0};

`ifdef BCD_DIGIT_STREAM_EN
  localparam int IDX_W = $clog2(NDIG + 1);

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;

  assign idx_nxt = idx + 1'b1;

  // Conversion FSM with registered handshake and digit-stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sreg        <= '0;
      cnt         <= '0;
      idx         <= '0;
      IN_READY    <= 1'b1;
      OUT_VALID   <= 1'b0;
      BCD_OUT     <= '0;
      DIGIT_OUT   <= '0;
      DIGIT_VALID <= 1'b0;
      DIGIT_LAST  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (IN_VALID) begin
            sreg     <= {{BCD_W{1'b0}}, B_IN};
            cnt      <= CNT_W'(WIDTH);
            IN_READY <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          sreg <= sreg_shl;
          cnt  <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            BCD_OUT     <= sreg_shl[WIDTH +: BCD_W];
            DIGIT_OUT   <= sreg_shl[WIDTH +: DIGIT_W];
            DIGIT_VALID <= 1'b1;
            DIGIT_LAST  <= (NDIG == 1);
            idx         <= '0;
            state       <= STREAM;
          end
        end
        STREAM: begin
          if (DIGIT_READY) begin
            if (idx == IDX_W'(NDIG - 1)) begin
              DIGIT_OUT   <= '0;
              DIGIT_VALID <= 1'b0;
              DIGIT_LAST  <= 1'b0;
              idx         <= '0;
              OUT_VALID   <= 1'b1;
              state       <= DONE;
            end else begin
              idx        <= idx_nxt;
              DIGIT_OUT  <= BCD_OUT[idx_nxt*DIGIT_W +: DIGIT_W];
              DIGIT_LAST <= (idx_nxt == IDX_W'(NDIG - 1));
            end
          end
        end
        DONE: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            IN_READY  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic unused_digit_ready;

  assign unused_digit_ready = DIGIT_READY;
  assign DIGIT_OUT          = '0;
  assign DIGIT_VALID        = 1'b0;
  assign DIGIT_LAST         = 1'b0;

  // Conversion FSM with registered handshake outputs; no digit streaming.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      IN_READY  <= 1'b1;
      OUT_VALID <= 1'b0;
      BCD_OUT   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (IN_VALID) begin
            sreg     <= {{BCD_W{1'b0}}, B_IN};
            cnt      <= CNT_W'(WIDTH);
            IN_READY <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          sreg <= sreg_shl;
          cnt  <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            BCD_OUT   <= sreg_shl[WIDTH +: BCD_W];
            OUT_VALID <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            IN_READY  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (WIDTH=8, NDIG=3). A transaction-level
// model predicts handshake timing and results from decimal arithmetic; a
// negedge compare process checks the DUT against it every cycle, and directed
// tests pin literal results and latencies.
module tb_bin_to_bcd_seq;

  localparam int WIDTH = 8;
  localparam int NDIG  = 3;
`ifdef BCD_DIGIT_STREAM_EN
  localparam int LAT = WIDTH + NDIG;
`else
  localparam int LAT = WIDTH;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [WIDTH-1:0]  B_IN;
  logic              IN_VALID;
  logic              IN_READY;
  logic [4*NDIG-1:0] BCD_OUT;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [3:0]        DIGIT_OUT;
  logic              DIGIT_VALID;
  logic              DIGIT_LAST;
  logic              DIGIT_READY;

  bin_to_bcd_seq #(.WIDTH(WIDTH), .NDIG(NDIG)) dut (
    .clk         (clk),
    .rst         (rst),
    .B_IN        (B_IN),
    .IN_VALID    (IN_VALID),
    .IN_READY    (IN_READY),
    .BCD_OUT     (BCD_OUT),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .DIGIT_OUT   (DIGIT_OUT),
    .DIGIT_VALID (DIGIT_VALID),
    .DIGIT_LAST  (DIGIT_LAST),
    .DIGIT_READY (DIGIT_READY)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int cyc = 0;

  // Model state
  bit m_in_ready  = 1'b1;
  bit m_out_valid = 1'b0;
  int m_bcd       = 0;
  int m_left      = 0;
  int m_val       = 0;
  int m_dq[$];

  // DUT observations
  int dut_acc[$];
  int dut_res[$];
  int dut_xfer[$];

  function automatic void chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic int to_bcd(input int v);
    int r = 0;
    for (int i = 0; i < NDIG; i++) begin
      r = r | ((v % 10) << (4 * i));
      v = v / 10;
    end
    return r;
  endfunction

  // Record DUT handshakes, then advance the reference model one clock.
  always @(posedge clk) begin
    cyc++;
    if (!rst && IN_VALID && IN_READY) dut_acc.push_back(cyc);
    if (!rst && OUT_VALID && OUT_READY) dut_res.push_back(int'(BCD_OUT));
    if (!rst && DIGIT_VALID && DIGIT_READY) dut_xfer.push_back(int'(DIGIT_OUT));

    if (rst) begin
      m_in_ready  = 1'b1;
      m_out_valid = 1'b0;
      m_bcd       = 0;
      m_left      = 0;
      m_dq.delete();
    end else if (m_in_ready) begin
      if (IN_VALID) begin
        m_in_ready = 1'b0;
        m_left     = WIDTH;
        m_val      = int'(B_IN);
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_bcd = to_bcd(m_val);
`ifdef BCD_DIGIT_STREAM_EN
        begin
          int v = m_val;
          for (int i = 0; i < NDIG; i++) begin
            m_dq.push_back(v % 10);
            v = v / 10;
          end
        end
`else
        m_out_valid = 1'b1;
`endif
      end
    end else if (m_dq.size() > 0) begin
      if (DIGIT_READY) begin
        void'(m_dq.pop_front());
        if (m_dq.size() == 0) m_out_valid = 1'b1;
      end
    end else if (m_out_valid && OUT_READY) begin
      m_out_valid = 1'b0;
      m_in_ready  = 1'b1;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", int'(IN_READY), int'(m_in_ready));
      chk("out_valid", int'(OUT_VALID), int'(m_out_valid));
      chk("bcd_out", int'(BCD_OUT), m_bcd);
`ifdef BCD_DIGIT_STREAM_EN
      chk("digit_valid", int'(DIGIT_VALID), int'(m_dq.size() > 0));
      if (m_dq.size() > 0) begin
        chk("digit_out", int'(DIGIT_OUT), m_dq[0]);
        chk("digit_last", int'(DIGIT_LAST), int'(m_dq.size() == 1));
      end else begin
        chk("digit_last_idle", int'(DIGIT_LAST), 0);
      end
`else
      chk("digit_out_tied", int'(DIGIT_OUT), 0);
      chk("digit_valid_tied", int'(DIGIT_VALID), 0);
      chk("digit_last_tied", int'(DIGIT_LAST), 0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    int n = 0;
    while (!IN_READY && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("send_timeout", 0, 1);
    B_IN     = v[WIDTH-1:0];
    IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
  endtask

  task automatic wait_out(output int k);
    k = 0;
    while (!OUT_VALID && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic release_out();
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
  endtask

  task automatic conv(input string nm, input int v, input int exp);
    int k;
    send(v);
    wait_out(k);
    chk({nm, "_latency"}, k, LAT);
    chk({nm, "_bcd"}, int'(BCD_OUT), exp);
    release_out();
  endtask

  initial begin
    int k;
    rst         = 1'b1;
    B_IN        = '0;
    IN_VALID    = 1'b0;
    OUT_READY   = 1'b0;
    DIGIT_READY = 1'b1;
    tick();
    tick();
    chk_en = 1'b1;
    chk("rst_in_ready", int'(IN_READY), 1);
    chk("rst_out_valid", int'(OUT_VALID), 0);
    chk("rst_bcd_out", int'(BCD_OUT), 0);
    chk("rst_digit_valid", int'(DIGIT_VALID), 0);
    rst = 1'b0;
    tick();

    conv("c255", 255, 'h255);
    conv("c0", 0, 'h000);
    dut_xfer.delete();
    conv("c99", 99, 'h099);
`ifdef BCD_DIGIT_STREAM_EN
    chk("x99_count", dut_xfer.size(), 3);
    if (dut_xfer.size() == 3) begin
      chk("x99_d0", dut_xfer[0], 9);
      chk("x99_d1", dut_xfer[1], 9);
      chk("x99_d2", dut_xfer[2], 0);
      chk("x99_xs3_d0", dut_xfer[0] + 3, 'b1100);
      chk("x99_xs3_d2", dut_xfer[2] + 3, 'b0011);
    end
`endif

    // Result held while the consumer stalls; new input ignored.
    send(123);
    wait_out(k);
    for (int i = 0; i < 5; i++) begin
      IN_VALID = 1'b1;
      B_IN     = 8'd7;
      tick();
      chk("hold_out_valid", int'(OUT_VALID), 1);
      chk("hold_bcd", int'(BCD_OUT), 'h123);
      chk("hold_in_ready", int'(IN_READY), 0);
    end
    IN_VALID = 1'b0;
    release_out();
    chk("hold_release_in_ready", int'(IN_READY), 1);
    tick();
    chk("hold_no_accept", int'(IN_READY), 1);

`ifdef BCD_DIGIT_STREAM_EN
    // Back-pressured digit stream.
    dut_xfer.delete();
    send(128);
    k = 0;
    while (!DIGIT_VALID && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) chk("digit_valid_timeout", 0, 1);
    for (int i = 0; i < 5; i++) begin
      DIGIT_READY = (i % 2 == 0);
      tick();
    end
    DIGIT_READY = 1'b1;
    wait_out(k);
    chk("x128_count", dut_xfer.size(), 3);
    if (dut_xfer.size() == 3) begin
      chk("x128_d0", dut_xfer[0], 8);
      chk("x128_d1", dut_xfer[1], 2);
      chk("x128_d2", dut_xfer[2], 1);
    end
    chk("x128_bcd", int'(BCD_OUT), 'h128);
    release_out();
`endif

    // Reset mid-conversion.
    send(200);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", int'(IN_READY), 1);
    chk("midrst_out_valid", int'(OUT_VALID), 0);
    chk("midrst_bcd", int'(BCD_OUT), 0);
    chk("midrst_digit_valid", int'(DIGIT_VALID), 0);
    conv("c200", 200, 'h200);

    // Back-to-back with the consumer always ready.
    OUT_READY = 1'b1;
    dut_acc.delete();
    dut_res.delete();
    send(37);
    send(150);
    send(9);
    k = 0;
    while (dut_res.size() < 3 && k < 200) begin
      tick();
      k++;
    end
    chk("b2b_count", dut_res.size(), 3);
    if (dut_res.size() == 3) begin
      chk("b2b_r0", dut_res[0], 'h037);
      chk("b2b_r1", dut_res[1], 'h150);
      chk("b2b_r2", dut_res[2], 'h009);
    end
    if (dut_acc.size() == 3) begin
      chk("b2b_gap1", dut_acc[1] - dut_acc[0], LAT + 2);
      chk("b2b_gap2", dut_acc[2] - dut_acc[1], LAT + 2);
    end else begin
      chk("b2b_accepts", dut_acc.size(), 3);
    end
    OUT_READY = 1'b0;

    // Randomized traffic, including occasional resets.
    for (int i = 0; i < 1500; i++) begin
      IN_VALID    = ($urandom_range(0, 1) == 1);
      B_IN        = WIDTH'($urandom_range(0, 255));
      OUT_READY   = ($urandom_range(0, 2) != 0);
      DIGIT_READY = ($urandom_range(0, 1) == 1);
      rst         = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst      = 1'b0;
    IN_VALID = 1'b0;
    tick();
    tick();
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
